// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the IF and DM requesters, with DM priority
// and an IF starvation limit. Define MEM_ARB_STATS_EN to add grant and conflict counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,

  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [DATA_W-1:0] o_dm_rdata,

  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data_write,
  output logic              o_mem_write_en,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]       o_stat_if_grants,
  output logic [31:0]       o_stat_dm_grants,
  output logic [31:0]       o_stat_conflicts,
`endif
  input  logic [DATA_W-1:0] i_mem_data
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_dm_rdata;

  logic              w_if_prio;
  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic [ADDR_W-1:0] w_mem_address;
  logic [DATA_W-1:0] w_mem_data_write;
  logic              w_mem_write_en;

  // Grant selection: DM first unless IF has waited MAX_WAIT cycles; nothing while in reset.
  always_comb begin
    w_if_prio = (r_wait_cnt == WAIT_LIM);
    w_if_gnt  = 1'b0;
    w_dm_gnt  = 1'b0;
    if (!i_rst) begin
      if (i_dm_req && !(w_if_prio && i_if_req)) begin
        w_dm_gnt = 1'b1;
      end else if (i_if_req) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  // Memory port mux; idle drives all zeros.
  always_comb begin
    w_mem_address    = '0;
    w_mem_data_write = '0;
    w_mem_write_en   = 1'b0;
    if (w_dm_gnt) begin
      w_mem_address    = i_dm_addr;
      w_mem_data_write = i_dm_wdata;
      w_mem_write_en   = i_dm_we;
    end else if (w_if_gnt) begin
      w_mem_address    = i_if_addr;
    end
  end

  // Consecutive denied IF cycles; any IF grant or dropped request restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (!i_if_req || w_if_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_LIM) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Per-port read responses; rdata holds until that port's next read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_dm_rvalid <= w_dm_gnt && !i_dm_we;
      if (w_if_gnt) begin
        r_if_rdata <= i_mem_data;
      end
      if (w_dm_gnt && !i_dm_we) begin
        r_dm_rdata <= i_mem_data;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_if_grants;
  logic [31:0] r_stat_dm_grants;
  logic [31:0] r_stat_conflicts;

  // Free-running wrap-around counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_if_grants <= '0;
      r_stat_dm_grants <= '0;
      r_stat_conflicts <= '0;
    end else begin
      if (w_if_gnt) r_stat_if_grants <= r_stat_if_grants + 32'(1);
      if (w_dm_gnt) r_stat_dm_grants <= r_stat_dm_grants + 32'(1);
      if (i_if_req && i_dm_req) r_stat_conflicts <= r_stat_conflicts + 32'(1);
    end
  end

  assign o_stat_if_grants = r_stat_if_grants;
  assign o_stat_dm_grants = r_stat_dm_grants;
  assign o_stat_conflicts = r_stat_conflicts;
`endif

  assign o_if_gnt         = w_if_gnt;
  assign o_dm_gnt         = w_dm_gnt;
  assign o_if_rvalid      = r_if_rvalid;
  assign o_if_rdata       = r_if_rdata;
  assign o_dm_rvalid      = r_dm_rvalid;
  assign o_dm_rdata       = r_dm_rdata;
  assign o_mem_address    = w_mem_address;
  assign o_mem_data_write = w_mem_data_write;
  assign o_mem_write_en   = w_mem_write_en;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-port unified memory between the instruction-fetch (IF) requester and the load/store (DM) requester of the core.
- Sits between the core and the memory block.
- Drives the memory's address, write-data and write-enable inputs from the granted port; the memory's read data is combinational.
- Captures read data into a per-port response register.
- Arbitration is fixed-priority to DM, with a starvation limit that forces an IF grant.

Parameters:
ADDR_W, 32, width of all addresses (matches addr_t)
DATA_W, 32, width of all data (matches data_t)
MAX_WAIT, 4, consecutive denied IF cycles before IF gets priority; legal range 1..15

Ports:
i_clk  input  1  clock, all state updates on posedge
i_rst  input  1  synchronous reset, active-high
i_if_req  input  1  IF read request; held with address stable until o_if_gnt
i_if_addr  input  ADDR_W  IF read address
o_if_gnt  output  1  IF request accepted this cycle (combinational)
o_if_rvalid  output  1  IF read data valid (registered, one-cycle pulse)
o_if_rdata  output  DATA_W  IF read data (registered)
i_dm_req  input  1  DM request; held stable until o_dm_gnt
i_dm_we  input  1  DM write (1) / read (0)
i_dm_addr  input  ADDR_W  DM address
i_dm_wdata  input  DATA_W  DM write data
o_dm_gnt  output  1  DM request accepted this cycle (combinational)
o_dm_rvalid  output  1  DM read data valid (registered, reads only)
o_dm_rdata  output  DATA_W  DM read data (registered)
o_mem_address  output  ADDR_W  to memory address input
o_mem_data_write  output  DATA_W  to memory write-data input
o_mem_write_en  output  1  to memory write-enable input
i_mem_data  input  DATA_W  from memory read-data output (combinational)

Behaviour:
- Reset, synchronous and active-high:
  - o_if_rvalid, o_dm_rvalid = 0.
  - o_if_rdata, o_dm_rdata = 0.
  - Wait counter = 0.
  - While i_rst is high, o_if_gnt, o_dm_gnt and o_mem_write_en are forced to 0.
- Grant, combinational: at most one grant per cycle.
  - if_prio = (wait_cnt == MAX_WAIT).
  - DM wins when i_dm_req && !(if_prio && i_if_req).
  - Otherwise IF wins when i_if_req.
  - With no request, nothing is granted.
- Memory drive:
  - DM granted: o_mem_address = i_dm_addr, o_mem_data_write = i_dm_wdata, o_mem_write_en = i_dm_we.
  - IF granted: o_mem_address = i_if_addr, o_mem_write_en = 0.
  - Idle: address = 0, write_en = 0, o_mem_data_write = 0.
- Latency: a grant in cycle N gives rvalid in cycle N+1, for exactly one cycle.
  - rdata = i_mem_data sampled at the end of cycle N.
  - rdata holds its value until the next read on that port.
- Writes: complete at the grant edge. No o_dm_rvalid and no o_dm_rdata change.
- Wait counter, 4 bits:
  - Increments when i_if_req && !o_if_gnt, saturating at MAX_WAIT.
  - Clears on an IF grant or when i_if_req is low.
- Back-to-back: grants are allowed every cycle, and a port may be granted in consecutive cycles.
- Simultaneous events:
  - Both requesting, counter < MAX_WAIT: DM granted.
  - Counter == MAX_WAIT: IF granted and the counter clears the same edge.
- Reset mid-operation: a grant in the cycle with i_rst high is impossible. If reset asserts in the cycle after a grant, rvalid is 0 after that edge.
- Read-after-write: a DM write in cycle N followed by any read of the same address in cycle N+1 returns the written data.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined, adds three 32-bit output ports, all wrapping on overflow and cleared by i_rst:
  - o_stat_if_grants: IF grant count.
  - o_stat_dm_grants: DM grant count.
  - o_stat_conflicts: cycles with both requests high.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Memory word 0x10 = 0xDEADBEEF, IF-only req addr 0x10 in cycle 1 -> o_if_gnt=1 in cycle 1; cycle 2 o_if_rvalid=1 with o_if_rdata=0xDEADBEEF; cycle 3 rvalid=0 and rdata held.
- IF and DM read together (IF 0x4, DM 0x8) -> DM granted cycle 1, IF granted cycle 2; rvalids in cycles 2 and 3 with the correct words.
- DM requests every cycle, IF held, MAX_WAIT=4 -> IF denied cycles 1-4, granted cycle 5; DM denied cycle 5, granted cycle 6; counter back at 0.
- DM write 0x5 to addr 3 in cycle 1 -> o_mem_write_en=1 for cycle 1 only, no o_dm_rvalid; IF read addr 3 in cycle 2 -> o_if_rdata=0x5 in cycle 3.
- IF granted in cycle 1, i_rst=1 in cycle 2 -> o_if_rvalid=0 and rdata=0 after the cycle-2 edge; no grants while reset is high; normal operation after release.
- With MEM_ARB_STATS_EN: 3 conflict cycles plus 2 IF-only cycles -> conflicts=3; grant counters sum to 5.
